// File: rtl/tone_period_meter_if.sv
// tone_period_meter_if: bundles the audio input and measurement results of tone_period_meter.
//   audio_in     - raw square-wave input (asynchronous to clk)
//   period_out   - last accepted period in clk cycles, rising edge to rising edge
//   period_valid - one-cycle pulse when period_out updates
//   tone_present - high while a tone is being measured
//   tone_stable  - last two accepted periods are within tolerance
//   edge_count   - accepted rising edges, wraps at 255 -> 0
// Modports: master = meter side (drives results), slave = consumer side (drives audio_in).
interface tone_period_meter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             audio_in;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             tone_present;
    logic             tone_stable;
    logic [7:0]       edge_count;

    modport master (
        input  audio_in,
        output period_out,
        output period_valid,
        output tone_present,
        output tone_stable,
        output edge_count
    );

    modport slave (
        output audio_in,
        input  period_out,
        input  period_valid,
        input  tone_present,
        input  tone_stable,
        input  edge_count
    );
endinterface

// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the period of a square-wave audio input in clk cycles and
// reports tone presence and stability.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - tone_period_meter_if.master (audio_in in; period_out, period_valid,
//           tone_present, tone_stable, edge_count out)
// Latency: audio_in rise -> period_valid/period_out update at the 4th clk edge.
module tone_period_meter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_PERIOD = 50000,
    parameter int unsigned MIN_PERIOD = 4,
    parameter int unsigned TOL        = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    tone_period_meter_if.master        bus
);

    typedef enum logic [1:0] {StSilent, StArmed, StMeasure} state_e;

    localparam logic [CNT_W-1:0] MaxP = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] MinP = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W:0]   Tol  = (CNT_W+1)'(TOL);

    state_e           state_q, state_d;
    logic [2:0]       sync_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             valid_q, valid_d;
    logic             stable_q, stable_d;
    logic             present_q;
    logic [7:0]       edges_q, edges_d;

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;
    logic             long_enough;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]   abs_diff;
    logic             within_tol;

    // Two synchronizer flops plus one edge-detect flop; rise_q is registered so the
    // FSM reacts on the 4th edge after audio_in rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], bus.audio_in};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign period      = cnt_q + CNT_W'(1);
    assign cnt_inc     = (cnt_q >= MaxP) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout     = (period >= MaxP);
    assign long_enough = (period >= MinP);
    assign diff        = $signed({1'b0, period}) - $signed({1'b0, prev_q});
    assign abs_diff    = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign within_tol  = (abs_diff <= Tol);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StSilent;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a rise always wins over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSilent: begin
                if (rise_q) state_d = StArmed;
            end
            StArmed: begin
                if (rise_q) begin
                    if (long_enough) state_d = StMeasure;
                end else if (timeout) begin
                    state_d = StSilent;
                end
            end
            StMeasure: begin
                if (!rise_q && timeout) state_d = StSilent;
            end
            default: state_d = StSilent;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        prev_d   = prev_q;
        valid_d  = 1'b0;
        stable_d = stable_q;
        edges_d  = edges_q;
        unique case (state_q)
            StSilent: begin
                cnt_d = '0;
            end
            StArmed: begin
                if (rise_q) begin
                    cnt_d = '0;
                    if (long_enough) begin
                        period_d = period;
                        prev_d   = period;
                        valid_d  = 1'b1;
                        edges_d  = edges_q + 8'd1;
                        stable_d = 1'b0;
                    end
                end else if (timeout) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StMeasure: begin
                if (rise_q) begin
                    cnt_d = '0;
                    if (long_enough) begin
                        period_d = period;
                        prev_d   = period;
                        valid_d  = 1'b1;
                        edges_d  = edges_q + 8'd1;
                        stable_d = within_tol;
                    end else begin
                        // Glitch: restart timing, drop stability, keep the last period.
                        stable_d = 1'b0;
                    end
                end else if (timeout) begin
                    cnt_d    = '0;
                    stable_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d    = '0;
                stable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            period_q  <= '0;
            prev_q    <= '0;
            valid_q   <= 1'b0;
            stable_q  <= 1'b0;
            present_q <= 1'b0;
            edges_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            prev_q    <= prev_d;
            valid_q   <= valid_d;
            stable_q  <= stable_d;
            present_q <= (state_d == StMeasure);
            edges_q   <= edges_d;
        end
    end

    assign bus.period_out   = period_q;
    assign bus.period_valid = valid_q;
    assign bus.tone_present = present_q;
    assign bus.tone_stable  = stable_q;
    assign bus.edge_count   = edges_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed testbench for tone_period_meter (MAX_PERIOD=1000, MIN_PERIOD=4, TOL=2).
module tb_tone_period_meter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   pulse_cnt;
    int   p0;

    tone_period_meter_if #(.CNT_W(16)) bus ();

    tone_period_meter #(
        .CNT_W      (16),
        .MAX_PERIOD (1000),
        .MIN_PERIOD (4),
        .TOL        (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count period_valid pulses; a stuck-high pulse shows up as extra counts.
    initial pulse_cnt = 0;
    always @(negedge clk) begin
        if (bus.period_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.audio_in = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One square-wave cycle: rising edge now, next rise after 'period' cycles.
    task automatic tone_cycle(input int period);
        bus.audio_in = 1'b1;
        repeat (period / 2) @(negedge clk);
        bus.audio_in = 1'b0;
        repeat (period - period / 2) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.audio_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);

        // 1. Reset then idle
        do_reset();
        check("rst_period",  32'(bus.period_out), 0);
        check("rst_valid",   32'(bus.period_valid), 0);
        check("rst_present", 32'(bus.tone_present), 0);
        check("rst_stable",  32'(bus.tone_stable), 0);
        check("rst_edges",   32'(bus.edge_count), 0);
        p0 = pulse_cnt;
        repeat (2000) @(negedge clk);
        check("idle_pulses",  32'(pulse_cnt - p0), 0);
        check("idle_present", 32'(bus.tone_present), 0);
        check("idle_period",  32'(bus.period_out), 0);
        check("idle_edges",   32'(bus.edge_count), 0);

        // MIN_PERIOD boundary: periods of 3 rejected, 4 accepted
        do_reset();
        p0 = pulse_cnt;
        tone_cycle(3);
        tone_cycle(3);
        tone_cycle(4);
        tone_cycle(4);
        repeat (10) @(negedge clk);
        check("min_pulses",  32'(pulse_cnt - p0), 1);
        check("min_period",  32'(bus.period_out), 4);
        check("min_present", 32'(bus.tone_present), 1);
        check("min_edges",   32'(bus.edge_count), 1);

        // 2. Steady 100-cycle tone, 6 rises
        do_reset();
        p0 = pulse_cnt;
        tone_cycle(100);
        check("st_arm_present", 32'(bus.tone_present), 0);
        check("st_arm_pulses",  32'(pulse_cnt - p0), 0);
        tone_cycle(100);
        check("st_r2_present", 32'(bus.tone_present), 1);
        check("st_r2_stable",  32'(bus.tone_stable), 0);
        check("st_r2_period",  32'(bus.period_out), 100);
        tone_cycle(100);
        check("st_r3_stable", 32'(bus.tone_stable), 1);
        tone_cycle(100);
        tone_cycle(100);
        tone_cycle(100);
        check("st_pulses", 32'(pulse_cnt - p0), 5);
        check("st_period", 32'(bus.period_out), 100);
        check("st_edges",  32'(bus.edge_count), 5);
        check("st_stable", 32'(bus.tone_stable), 1);

        // 3. Jitter: periods 100, 101, 99, 104
        do_reset();
        tone_cycle(100);
        tone_cycle(101);
        tone_cycle(99);
        check("jit_r3_period", 32'(bus.period_out), 101);
        check("jit_r3_stable", 32'(bus.tone_stable), 1);
        tone_cycle(104);
        check("jit_r4_period", 32'(bus.period_out), 99);
        check("jit_r4_stable", 32'(bus.tone_stable), 1);
        tone_cycle(100);
        check("jit_r5_period", 32'(bus.period_out), 104);
        check("jit_r5_stable", 32'(bus.tone_stable), 0);

        // 4. Glitch two cycles after a rise
        do_reset();
        tone_cycle(100);
        tone_cycle(100);
        tone_cycle(100);
        p0 = pulse_cnt;
        bus.audio_in = 1'b1;
        @(negedge clk);
        bus.audio_in = 1'b0;
        @(negedge clk);
        bus.audio_in = 1'b1;
        repeat (48) @(negedge clk);
        check("gl_pulses",  32'(pulse_cnt - p0), 1);
        check("gl_period",  32'(bus.period_out), 100);
        check("gl_stable",  32'(bus.tone_stable), 0);
        check("gl_present", 32'(bus.tone_present), 1);
        bus.audio_in = 1'b0;
        repeat (50) @(negedge clk);
        tone_cycle(100);
        check("gl_next_period", 32'(bus.period_out), 98);
        check("gl_next_pulses", 32'(pulse_cnt - p0), 2);
        check("gl_next_stable", 32'(bus.tone_stable), 1);
        check("gl_edges",       32'(bus.edge_count), 4);

        // 5. Timeout: tone stops high
        do_reset();
        tone_cycle(100);
        tone_cycle(100);
        tone_cycle(100);
        bus.audio_in = 1'b1;
        repeat (900) @(negedge clk);
        check("to_pre_present", 32'(bus.tone_present), 1);
        check("to_pre_stable",  32'(bus.tone_stable), 1);
        repeat (110) @(negedge clk);
        check("to_present", 32'(bus.tone_present), 0);
        check("to_stable",  32'(bus.tone_stable), 0);
        check("to_period",  32'(bus.period_out), 100);
        check("to_edges",   32'(bus.edge_count), 3);
        bus.audio_in = 1'b0;
        repeat (10) @(negedge clk);
        p0 = pulse_cnt;
        tone_cycle(100);
        check("to_arm_present", 32'(bus.tone_present), 0);
        check("to_arm_pulses",  32'(pulse_cnt - p0), 0);
        check("to_arm_edges",   32'(bus.edge_count), 3);
        tone_cycle(100);
        check("to_re_present", 32'(bus.tone_present), 1);
        check("to_re_edges",   32'(bus.edge_count), 4);

        // 6. edge_count wrap, then asynchronous reset mid-period
        do_reset();
        for (int i = 0; i < 261; i++) tone_cycle(10);
        check("wr_edges",   32'(bus.edge_count), 4);
        check("wr_period",  32'(bus.period_out), 10);
        check("wr_present", 32'(bus.tone_present), 1);
        check("wr_stable",  32'(bus.tone_stable), 1);
        bus.audio_in = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_period",  32'(bus.period_out), 0);
        check("ar_present", 32'(bus.tone_present), 0);
        check("ar_stable",  32'(bus.tone_stable), 0);
        check("ar_edges",   32'(bus.edge_count), 0);
        check("ar_valid",   32'(bus.period_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
